// File: rtl/fpu_operand_feeder.sv
// Operand feeder for the FPU: buffers IEEE-754 single-precision pairs, converts them to the
// FPU internal format (bias 511, 21-bit fraction) and holds each pair stable for HOLD_CYCLES.
// Optional build macro FEEDER_ROUND_EN selects round-to-nearest-even instead of truncation.
module fpu_operand_feeder #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 32
) (
    input  logic                     clock_100Khz,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic [31:0]              Op_A_out,
    output logic [31:0]              Op_B_out,
    output logic                     op_active,
    output logic [2:0]               conv_flags,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    // Result layout: {inexact, denorm_flushed, special, converted[31:0]}
    function automatic logic [34:0] convertOperand(input logic [31:0] x);
        logic        s;
        logic [7:0]  e8;
        logic [22:0] f23;
        logic [9:0]  exp10;
        logic [20:0] mant21;
        logic        inexact;
        logic        denorm;
        logic        special;
        logic [31:0] result;
`ifdef FEEDER_ROUND_EN
        logic        carry;
`endif
        s       = x[31];
        e8      = x[30:23];
        f23     = x[22:0];
        exp10   = '0;
        mant21  = '0;
        inexact = 1'b0;
        denorm  = 1'b0;
        special = 1'b0;
        if (e8 == 8'd0) begin
            denorm = (f23 != 23'd0);
            result = {s, 31'd0};
        end else if (e8 == 8'hFF) begin
            special = 1'b1;
            result  = {s, 10'd1023, (f23 == 23'd0) ? 21'd0 : 21'h100000};
        end else begin
            exp10   = {2'b00, e8} + 10'd384;
            mant21  = f23[22:2];
            inexact = (f23[1:0] != 2'b00);
`ifdef FEEDER_ROUND_EN
            // Guard = f23[1], sticky = f23[0], LSB = f23[2]; a carry out renormalises.
            if (f23[1] && (f23[0] || f23[2])) begin
                {carry, mant21} = {1'b0, mant21} + 22'd1;
                if (carry) begin
                    exp10 = exp10 + 10'd1;
                end
            end
`endif
            result = {s, exp10, mant21};
        end
        return {inexact, denorm, special, result};
    endfunction

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    holdCnt_q, holdCnt_d;
    logic          active_q, active_d;
    logic [31:0]   rawA_q, rawA_d, rawB_q, rawB_d;
    logic [31:0]   opA_q, opA_d, opB_q, opB_d;
    logic [2:0]    flags_q, flags_d;
    logic          push, pop;
    logic [34:0]   convA, convB;

    assign in_ready   = (count_q != FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign convA      = convertOperand(rawA_q);
    assign convB      = convertOperand(rawB_q);
    assign Op_A_out   = opA_q;
    assign Op_B_out   = opB_q;
    assign op_active  = active_q;
    assign conv_flags = flags_q;
    assign fifo_count = count_q;

    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        active_d  = active_q;
        rawA_d    = rawA_q;
        rawB_d    = rawB_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        flags_d   = flags_q;
        rdPtr_d   = rdPtr_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop              = 1'b1;
                    {rawA_d, rawB_d} = mem_q[rdPtr_q];
                    rdPtr_d          = rdPtr_q + 1'b1;
                    state_d          = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                opA_d     = convA[31:0];
                opB_d     = convB[31:0];
                flags_d   = convA[34:32] | convB[34:32];
                active_d  = 1'b1;
                holdCnt_d = HOLD_LOAD;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (holdCnt_q != 8'd0) begin
                    holdCnt_d = holdCnt_q - 8'd1;
                end else begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_100Khz) begin
        if (push) begin
            mem_q[wrPtr_q] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clock_100Khz) begin
        if (!reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            holdCnt_q <= '0;
            active_q  <= 1'b0;
            rawA_q    <= '0;
            rawB_q    <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            flags_q   <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            active_q  <= active_d;
            rawA_q    <= rawA_d;
            rawB_q    <= rawB_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: doc/fpu_operand_feeder.md
# fpu_operand_feeder

Upstream operand stage for the FPU. Accepts IEEE-754 single-precision operand pairs through a valid/ready handshake and buffers them in a small FIFO. Converts each pair to the FPU's internal 32-bit format: sign[31], exponent[30:21] with bias 511, fraction[20:0] with a hidden 1. Holds each converted pair stable on `Op_A_out`/`Op_B_out` for a fixed window so the FPU's DECODE→WRITEBACK loop samples one coherent pair.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; a power of two, at least 2.
- `HOLD_CYCLES`, default 32: cycles each converted pair is presented; at least 1 and at most 255; covers the FPU worst-case loop.

Ports:
- `clock_100Khz` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; sampled only on the rising edge of `clock_100Khz`.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a` in 32: IEEE-754 operand A.
- `in_b` in 32: IEEE-754 operand B.
- `Op_A_out` out 32: converted operand A, driven to FPU `Op_A_in`.
- `Op_B_out` out 32: converted operand B, driven to FPU `Op_B_in`.
- `op_active` out 1: high while the current pair is being presented.
- `conv_flags` out 3: {inexact, denorm_flushed, special}, OR of both operands of the presented pair.
- `fifo_count` out $clog2(DEPTH)+1: number of stored entries.

## Operation
- Push when `in_valid && in_ready`; pairs pop in FIFO order.
- FSM states: IDLE, CONVERT, HOLD.
  - IDLE: if the FIFO is non-empty, pop into the raw registers and go to CONVERT. Otherwise stay in IDLE.
  - CONVERT: register both conversions and `conv_flags`, set `op_active`=1, load hold counter = `HOLD_CYCLES`-1, go to HOLD.
  - HOLD: counter non-zero → decrement. Counter zero → `op_active`=0 and go to IDLE.
- Push and pop in the same cycle: `fifo_count` unchanged. `in_ready` = (`fifo_count` != `DEPTH`), so there is no push when full. A pop while full frees a slot, and `in_ready` rises on the next cycle.
- `Op_A_out`/`Op_B_out`/`conv_flags` keep their last value outside HOLD; they change only on the CONVERT edge.
- Conversion per operand: s = bit31, e8 = [30:23], f23 = [22:0].
  - e8=0, f23=0: output {s, 31'b0} (signed zero).
  - e8=0, f23≠0: flush to {s, 31'b0}; set denorm_flushed.
  - e8=255, f23=0: output {s, 10'd1023, 21'd0}; set special.
  - e8=255, f23≠0 (NaN): output {s, 10'd1023, 21'h100000}; set special.
  - Normal: exp10 = e8 + 384; mant21 = f23[22:2]; inexact if f23[1:0] ≠ 0.
  - Rounding applies to normal operands only. On mantissa carry: mant21 = 0 and exp10 += 1. The maximum result is 639, so there is no overflow.

## Timing
- Reset values: `in_ready`=1, `Op_A_out`=0, `Op_B_out`=0, `op_active`=0, `conv_flags`=0, `fifo_count`=0. State is IDLE and the FIFO pointers are 0.
- Reset low during HOLD or CONVERT aborts the operation on that edge and discards FIFO contents.
- Push at edge N into an empty FIFO with the FSM in IDLE:
  - Pop at edge N+1.
  - Outputs valid and `op_active`=1 from edge N+2.
- `op_active` is high for exactly `HOLD_CYCLES` cycles.
- Back-to-back pairs have a period of `HOLD_CYCLES`+2 cycles, with one IDLE and one CONVERT cycle between them.

## Configuration
- `FEEDER_ROUND_EN` defined: round-to-nearest-even on the dropped bits. Guard = f23[1], sticky = f23[0], LSB = f23[2]. Round up if guard && (sticky || LSB).
- `FEEDER_ROUND_EN` undefined: truncate; mant21 = f23[22:2] and there is no carry path.
- The inexact flag behaves identically in both builds.

## Test plan
- Reset then push a=0x3F800000, b=0x40000000 (1.0, 2.0):
  - `Op_A_out`=0x3FE00000 and `Op_B_out`=0x40000000 at push+2.
  - `op_active` high for 32 cycles.
  - `conv_flags`=0.
- Push a=0xBFC00000, b=0x80000000 → `Op_A_out`=0xBFF00000, `Op_B_out`=0x80000000, flags=0.
- Rounding, a=0x3F800003, 0x3F800002, 0x3FFFFFFF:
  - With `FEEDER_ROUND_EN`: 0x3FE00001, 0x3FE00000, 0x40000000.
  - Without `FEEDER_ROUND_EN`: 0x3FE00000, 0x3FE00000, 0x3FFFFFFF.
  - inexact=1 for each.
- Specials, a=0x7F800000, b=0x00000001 → `Op_A_out`=0x7FE00000, `Op_B_out`=0x00000000, `conv_flags`=3'b011. NaN 0x7FC00000 → 0x7FF00000.
- Push 5 pairs with `in_valid` held high and `DEPTH`=4:
  - `in_ready` drops when `fifo_count`=4.
  - The fifth pair is accepted after the first pop.
  - Pairs are presented in push order, spaced 34 cycles apart.
- Assert `reset` low mid-HOLD → next edge: `op_active`=0, outputs 0, `fifo_count`=0, `in_ready`=1.
